// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder with valid/ready handshakes.
// One full-adder cell (two half adders plus an OR for the carry) is reused
// LSB first over WIDTH cycles. A carry flop links consecutive bits.
// Optional feature macro: SERIAL_SUB_EN adds the 'sub' port for a-b mode.
// With SERIAL_SUB_EN undefined, the block only adds.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    bit_cnt_reg;

  logic             accept, last_bit;
  logic             h1, c1, s_bit, c2, carry_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
`ifdef SERIAL_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  assign accept   = in_valid && (state_reg == IDLE);
  assign last_bit = (bit_cnt_reg == LAST_BIT);

  // One-bit add cell: two half adders, carries merged with an OR.
  always_comb begin
    h1         = a_sr_reg[0] ^ b_sr_reg[0];
    c1         = a_sr_reg[0] & b_sr_reg[0];
    s_bit      = h1 ^ carry_reg;
    c2         = h1 & carry_reg;
    carry_next = c1 | c2;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand shift registers, carry chain, bit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg    <= '0;
      b_sr_reg    <= '0;
      sum_reg     <= '0;
      carry_reg   <= 1'b0;
      cout_reg    <= 1'b0;
      bit_cnt_reg <= '0;
    end else if (accept) begin
      a_sr_reg    <= a;
      b_sr_reg    <= b_load;
      carry_reg   <= carry_init;
      bit_cnt_reg <= '0;
    end else if (state_reg == SHIFT) begin
      a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
      b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
      sum_reg   <= {s_bit, sum_reg[WIDTH-1:1]};
      carry_reg <= carry_next;
      // Counter parks on the last bit rather than wrapping.
      if (last_bit) cout_reg    <= carry_next;
      else          bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
// Define SERIAL_SUB_EN to also exercise the subtract mode.
module tb_serial_add_ctrl;

`ifdef SERIAL_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       sub = 1'b0, cout, busy;

  logic       in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       sub2 = 1'b0, cout2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef SERIAL_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2),
`ifdef SERIAL_SUB_EN
    .sub(sub2),
`endif
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2),
    .busy(busy2)
  );

  // Drive one operand pair into dut8 and wait (bounded) for its result.
  // lat counts rising edges from the accepting edge to out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                        output int lat, output logic busy_seen);
    int g;
    @(negedge clk);
    a = ta; b = tbv; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = ~tbv;
    busy_seen = busy;
    lat = 0;
    while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
  endtask

  // Complete the output handshake on dut8.
  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({cout, sum} !== 9'h000) begin errors++; $display("FAIL reset_result got=%h exp=000", {cout, sum}); end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready2 got=%b exp=1", in_ready2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h33, 8'h01, 8'h00};
    logic [8:0] ve [3] = '{9'h08D, 9'h100, 9'h000};
    int lat;
    logic bs;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, lat, bs);
      $display("add a=%h b=%h -> sum=%h cout=%b lat=%0d", va[i], vb[i], sum, cout, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency[%0d] got=%0d exp=8", i, lat); end
      checks++; if (bs !== 1'b1) begin errors++; $display("FAIL add_busy[%0d] got=%b exp=1", i, bs); end
      checks++; if ({cout, sum} !== ve[i]) begin errors++; $display("FAIL add_result[%0d] got=%h exp=%h", i, {cout, sum}, ve[i]); end
      finish_op();
    end
  endtask

  task automatic test_hold_done();
    int lat;
    logic bs;
    run_op(8'h5A, 8'h33, 1'b0, lat, bs);
    $display("hold a=5a b=33 -> sum=%h cout=%b", sum, cout);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; a = 8'hC3; b = 8'h3C;
      @(negedge clk);
      checks++; if ({cout, sum} !== 9'h08D) begin errors++; $display("FAIL hold_result[%0d] got=%h exp=08d", k, {cout, sum}); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid[%0d] got=%b exp=1", k, out_valid); end
    end
    in_valid = 1'b0;
    finish_op();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 8'h8D) begin errors++; $display("FAIL hold_idle_sum got=%h exp=8d", sum); end
  endtask

  task automatic test_reset_mid_op();
    int g, lat;
    logic bs;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    $display("reset mid-op -> out_valid=%b sum=%h busy=%b in_ready=%b", out_valid, sum, busy, in_ready);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%h exp=00", sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h02, 1'b0, lat, bs);
    $display("add a=01 b=02 -> sum=%h cout=%b lat=%0d", sum, cout, lat);
    checks++; if ({cout, sum} !== 9'h003) begin errors++; $display("FAIL after_rst_result got=%h exp=003", {cout, sum}); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bs;
    run_op(8'h12, 8'h34, 1'b0, lat, bs);
    checks++; if ({cout, sum} !== 9'h046) begin errors++; $display("FAIL b2b_first got=%h exp=046", {cout, sum}); end
    a = 8'h80; b = 8'h80; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    lat = 0;
    while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
    $display("b2b a=80 b=80 -> sum=%h cout=%b lat=%0d", sum, cout, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    checks++; if ({cout, sum} !== 9'h100) begin errors++; $display("FAIL b2b_second got=%h exp=100", {cout, sum}); end
    finish_op();
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    int lat;
    logic bs;
    run_op(8'h10, 8'h01, 1'b1, lat, bs);
    $display("sub a=10 b=01 -> sum=%h cout=%b", sum, cout);
    checks++; if ({cout, sum} !== 9'h10F) begin errors++; $display("FAIL sub_10_01 got=%h exp=10f", {cout, sum}); end
    finish_op();
    run_op(8'h01, 8'h02, 1'b1, lat, bs);
    $display("sub a=01 b=02 -> sum=%h cout=%b", sum, cout);
    checks++; if ({cout, sum} !== 9'h0FF) begin errors++; $display("FAIL sub_01_02 got=%h exp=0ff", {cout, sum}); end
    finish_op();
    sub = 1'b0;
  endtask
`endif

  task automatic test_random8(input int n);
    logic [7:0] ra, rb;
    logic [8:0] exp9;
    int g;
    for (int i = 0; i < n; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = ra; b = rb; sub = HAS_SUB & 1'($urandom_range(0, 1)); in_valid = 1'b1;
      exp9 = sub ? (9'(ra) + 9'h100 - 9'(rb)) : (9'(ra) + 9'(rb));
      g = 0;
      while (!in_ready && g < 50) begin @(negedge clk); g++; end
      @(negedge clk);
      g = 0;
      while (!out_valid && g < 64) begin
        in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); out_ready = 1'($urandom);
        @(negedge clk); g++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      $display("rnd8 a=%h b=%h sub=%b -> %h exp %h", ra, rb, sub, {cout, sum}, exp9);
      checks++; if ({cout, sum} !== exp9) begin errors++; $display("FAIL rnd8[%0d] got=%h exp=%h", i, {cout, sum}, exp9); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_op();
    end
    sub = 1'b0;
  endtask

  task automatic test_random2(input int n);
    logic [1:0] ra, rb;
    logic [2:0] exp3;
    int g;
    for (int i = 0; i < n; i++) begin
      ra = 2'($urandom); rb = 2'($urandom);
      @(negedge clk);
      in_valid2 = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a2 = ra; b2 = rb; sub2 = HAS_SUB & 1'($urandom_range(0, 1)); in_valid2 = 1'b1;
      exp3 = sub2 ? (3'(ra) + 3'b100 - 3'(rb)) : (3'(ra) + 3'(rb));
      g = 0;
      while (!in_ready2 && g < 50) begin @(negedge clk); g++; end
      @(negedge clk);
      g = 0;
      while (!out_valid2 && g < 64) begin
        in_valid2 = 1'($urandom); a2 = 2'($urandom); b2 = 2'($urandom); out_ready2 = 1'($urandom);
        @(negedge clk); g++;
      end
      in_valid2 = 1'b0; out_ready2 = 1'b0;
      $display("rnd2 a=%h b=%h sub=%b -> %h exp %h", ra, rb, sub2, {cout2, sum2}, exp3);
      checks++; if ({cout2, sum2} !== exp3) begin errors++; $display("FAIL rnd2[%0d] got=%h exp=%h", i, {cout2, sum2}, exp3); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
    end
    sub2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_hold_done();
    test_reset_mid_op();
    test_back_to_back();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    test_random8(1000);
    test_random2(1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so a stuck handshake can never hang the run.
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
